// File: rtl/fir_sample_source.sv
// fir_sample_source: buffers host samples in a FIFO and replays them to a FIR
// input port, one sample per emission slot, with slots spaced 'interval' cycles.
// Optional build macro FIR_SAMPLE_SOURCE_UNDERRUN_CNT_EN adds a saturating
// 16-bit underrun_count output, cleared by rst and by start.
module fir_sample_source #(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned FIFO_DEPTH     = 16,
   parameter int unsigned INTERVAL_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [DATA_WIDTH-1:0]     wr_data,
   input  logic                      wr_valid,
   output logic                      wr_ready,
   input  logic [INTERVAL_WIDTH-1:0] interval,
   input  logic                      start,
   input  logic                      stop,
   output logic                      busy,
   output logic [DATA_WIDTH-1:0]     output_data,
   output logic                      output_data_flag,
`ifdef FIR_SAMPLE_SOURCE_UNDERRUN_CNT_EN
   output logic                      underrun,
   output logic [15:0]               underrun_count
`else
   output logic                      underrun
`endif
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   typedef enum logic {IDLE, RUN} state_e;

   state_e                    state_q, state_d;
   logic [AW:0]               wr_ptr_q, wr_ptr_d;
   logic [AW:0]               rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0]     mem_q [FIFO_DEPTH];
   logic [INTERVAL_WIDTH-1:0] cnt_q, cnt_d;
   logic [INTERVAL_WIDTH-1:0] reload;
   logic [DATA_WIDTH-1:0]     data_q, data_d;
   logic                      flag_q, flag_d;
   logic                      und_q, und_d;
   logic                      full, empty, push, pop, slot;

   // FIFO status; the extra pointer MSB separates full from empty
   always_comb begin
      empty = (wr_ptr_q == rd_ptr_q);
      full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
      push  = wr_valid && !full;
      // pop uses the registered empty flag, so a write landing in an empty
      // FIFO during a slot is never forwarded to that same slot
      pop   = slot && !empty;
      wr_ptr_d = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // FSM next state: stop has priority over start
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start && !stop) state_d = RUN;
         RUN:     if (stop)           state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: slot strobe and busy
   always_comb begin
      busy = (state_q == RUN);
      slot = (state_q == RUN) && (cnt_q == '0);
   end

   // slot counter and output register next-state
   always_comb begin
      reload = (interval == '0) ? '0 : interval - INTERVAL_WIDTH'(1);
      cnt_d  = cnt_q;
      if (state_q == IDLE) begin
         if (start && !stop) cnt_d = '0;
      end else if (slot) begin
         cnt_d = reload;
      end else begin
         cnt_d = cnt_q - INTERVAL_WIDTH'(1);
      end
      data_d = pop ? mem_q[rd_ptr_q[AW-1:0]] : data_q;
      flag_d = pop;
      und_d  = slot && empty;
   end

   // pointers, counter and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         data_q   <= '0;
         flag_q   <= 1'b0;
         und_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         flag_q   <= flag_d;
         und_q    <= und_d;
      end
   end

   // sample storage; contents are don't-care while the pointers say empty
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
   end

`ifdef FIR_SAMPLE_SOURCE_UNDERRUN_CNT_EN
   logic [15:0] ucnt_q, ucnt_d;

   // saturating underrun counter, cleared by start
   always_comb begin
      ucnt_d = ucnt_q;
      if (start)                         ucnt_d = '0;
      else if (und_d && ucnt_q != '1)    ucnt_d = ucnt_q + 16'd1;
   end

   // underrun counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ucnt_q <= '0;
      else     ucnt_q <= ucnt_d;
   end

   assign underrun_count = ucnt_q;
`endif

   assign wr_ready         = !full;
   assign output_data      = data_q;
   assign output_data_flag = flag_q;
   assign underrun         = und_q;

endmodule

// File: doc/fir_sample_source.md
FIR_SAMPLE_SOURCE -- requirements
Module: fir_sample_source

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8: sample width in bits.
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 16: sample buffer entries, a power of two of at least 2.
REQ-003 The module SHALL have parameter INTERVAL_WIDTH, default 16: width of the interval input.
REQ-004 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 wr_data  input  DATA_WIDTH  host sample to buffer.
REQ-008 wr_valid  input  1  host write request.
REQ-009 wr_ready  output  1  buffer can accept a sample, high when not full.
REQ-010 interval  input  INTERVAL_WIDTH  cycles between emission slots; 0 is treated as 1.
REQ-011 start  input  1  one-cycle pulse that begins streaming.
REQ-012 stop  input  1  one-cycle pulse that ends streaming.
REQ-013 busy  output  1  high while in RUN.
REQ-014 output_data  output  DATA_WIDTH  sample presented to the FIR input_data.
REQ-015 output_data_flag  output  1  one-cycle strobe, the FIR input_data_flag.
REQ-016 underrun  output  1  one-cycle pulse when a slot finds the buffer empty.

Function
REQ-017 The buffer SHALL be a FIFO that accepts a write on each edge where wr_valid and wr_ready are both high.
REQ-018 The FSM SHALL have the states IDLE and RUN; start in IDLE moves it to RUN, stop in RUN moves it to IDLE, and stop wins when stop and start are high together.
REQ-019 On entry to RUN the slot counter SHALL load 0, so the first slot occurs on the edge after the edge where start was sampled.
REQ-020 On each slot with the FIFO not empty, the module SHALL pop one entry, drive it on output_data, and set output_data_flag high for exactly one cycle.
REQ-021 On each slot with the FIFO empty, the module SHALL keep output_data_flag low and pulse underrun for one cycle.
REQ-022 At every slot the counter SHALL reload to max(interval,1)-1, so consecutive slots are exactly max(interval,1) cycles apart.
REQ-023 interval SHALL be sampled only at slot reload; a change takes effect from the next slot.
REQ-024 output_data SHALL hold the last emitted sample between strobes.
REQ-025 A write and a pop in the same cycle SHALL both succeed; a write that arrives while the FIFO is full SHALL be ignored and the count SHALL be unchanged.
REQ-026 When the FIFO is empty, a sample written in a slot cycle SHALL NOT be emitted in that same slot; no write-to-output bypass exists.
REQ-027 The pointers SHALL wrap modulo FIFO_DEPTH, and full and empty SHALL be distinguished by an extra pointer bit.
REQ-028 In IDLE the module SHALL generate no slots, and buffered data SHALL be retained across stop and start.
REQ-029 With interval=1 and data available, output_data_flag SHALL stay high on consecutive cycles, each cycle carrying a new sample.

Reset
REQ-030 Reset SHALL immediately force the state to IDLE and clear both pointers (FIFO empty) and the counter.
REQ-031 Reset SHALL immediately drive output_data=0, output_data_flag=0, underrun=0, busy=0 and wr_ready=1.
REQ-032 A reset in mid-stream SHALL discard buffered samples, and a strobe SHALL never be truncated or duplicated across reset release.

Configuration
REQ-033 The macro FIR_SAMPLE_SOURCE_UNDERRUN_CNT_EN SHALL control an underrun counter.
REQ-034 With FIR_SAMPLE_SOURCE_UNDERRUN_CNT_EN defined, the module SHALL add the output underrun_count (16 bits), which increments on each underrun pulse, saturates at 16'hFFFF, and is cleared by rst and by start.
REQ-035 Without FIR_SAMPLE_SOURCE_UNDERRUN_CNT_EN, the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-036 Scenario: write DE, AD, BE, EF; interval=10; start -> four flags exactly 10 cycles apart carrying DE, AD, BE, EF in order, then underrun pulses every 10 cycles.
REQ-037 Scenario: write 16 samples, then a 17th with FIFO_DEPTH=16 -> wr_ready low after the 16th, the 17th is dropped, and 16 samples are emitted.
REQ-038 Scenario: interval=0 with 3 buffered samples -> flag high for 3 consecutive cycles, then an underrun pulse.
REQ-039 Scenario: assert stop after 2 of 4 samples, then start again -> no slots while IDLE, and the remaining 2 samples are emitted after restart.
REQ-040 Scenario: assert rst 3 cycles after a strobe, with 5 samples buffered -> all outputs return to reset values at once, and no flag follows until new writes and a new start.
REQ-041 Scenario: build with FIR_SAMPLE_SOURCE_UNDERRUN_CNT_EN, interval=4, empty FIFO, run 40 cycles -> underrun_count=10, and it reads 0 after the next start.
